// File: rtl/microwave_timer_ctrl_pkg.sv
// microwave_pkg: shared state encoding, BCD digit type and 7-segment lookup
package microwave_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef logic [3:0] bcd_t;

    // Active-high segments {g,f,e,d,c,b,a} for digits 0..9
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Non-BCD codes blank the digit rather than showing garbage
    function automatic logic [6:0] bcd_seg(input bcd_t d);
        return (d <= 4'd9) ? SEG_TABLE[d] : 7'h00;
    endfunction

endpackage

// File: rtl/microwave_timer_ctrl_bcd_to_7seg.sv
// bcd_to_7seg: one BCD digit to active-high 7-segment pattern, blank when not BCD
module bcd_to_7seg
    import microwave_pkg::*;
(
    input  bcd_t       digit_i,
    output logic [6:0] segs_o
);

    assign segs_o = bcd_seg(digit_i);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad MM:SS entry, countdown, interlocks, power duty cycling and end beep
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter  int TICK_DIV   = 100,
    parameter  int MIN_DIGITS = 1,
    parameter  int PWR_LEVELS = 10,
    parameter  int QUICK_SECS = 30,
    parameter  int BEEP_TICKS = 3,
    localparam int NDIG       = MIN_DIGITS + 2,
    localparam int PW         = $clog2(PWR_LEVELS + 1)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [9:0]          keypad,
    input  logic                startn,
    input  logic                stopn,
    input  logic                clearn,
    input  logic                door_closed,
    input  logic [PW-1:0]       power_sel,
    output logic [4*NDIG-1:0]   time_bcd,
    output logic [7*NDIG-1:0]   segs,
    output logic [1:0]          state,
    output logic                mag_on,
    output logic                done,
    output logic                beep
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BEEP_TICKS + 1);
    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PWR_LEVELS - 1);
    localparam logic [PW-1:0] PWR_MAX    = PW'(PWR_LEVELS);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_TICKS - 1);
    localparam bcd_t QS_TENS = 4'(QUICK_SECS / 10);
    localparam bcd_t QS_ONES = 4'(QUICK_SECS % 10);

    logic [1:0]    state_q, state_d;
    bcd_t          dig_q [NDIG];
    bcd_t          dig_d [NDIG];
    bcd_t          dec   [NDIG];
    logic [CW-1:0] presc_q, presc_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] pwr_q, pwr_d;
    logic [BW-1:0] beep_q, beep_d;
    logic          done_q, done_d;
    logic          startn_q, stopn_q, clearn_q;
    logic [9:0]    keypad_q;
    logic          start_p, stop_p, clear_p, key_p, tick, time_zero, dec_zero, borrow;
    logic [PW-1:0] pwr_eff;
    bcd_t          key_dig;

    assign start_p = startn_q & ~startn;
    assign stop_p  = stopn_q & ~stopn;
    assign clear_p = clearn_q & ~clearn;
    assign key_p   = (|(keypad & ~keypad_q)) && $onehot(keypad);
    assign tick    = presc_q == TICK_LAST;
    assign pwr_eff = (power_sel == '0 || power_sel > PWR_MAX) ? PWR_MAX : power_sel;

    // Encode the pressed key; only meaningful when key_p says exactly one bit is set
    always_comb begin
        key_dig = '0;
        for (int k = 0; k < 10; k++)
            if (keypad[k]) key_dig = 4'(k);
    end

    // One-second BCD decrement: seconds first, then borrow through the minute digits
    always_comb begin
        dec = dig_q;
        borrow = 1'b0;
        time_zero = 1'b1;
        dec_zero = 1'b1;
        if (dig_q[0] != 4'd0) begin
            dec[0] = dig_q[0] - 4'd1;
        end else if (dig_q[1] != 4'd0) begin
            dec[1] = dig_q[1] - 4'd1;
            dec[0] = 4'd9;
        end else begin
            dec[1] = 4'd5;
            dec[0] = 4'd9;
            borrow = 1'b1;
            for (int i = 2; i < NDIG; i++) begin
                if (borrow) begin
                    dec[i] = (dig_q[i] == 4'd0) ? 4'd9 : dig_q[i] - 4'd1;
                    borrow = dig_q[i] == 4'd0;
                end
            end
        end
        for (int i = 0; i < NDIG; i++) begin
            time_zero = time_zero & (dig_q[i] == 4'd0);
            dec_zero  = dec_zero & (dec[i] == 4'd0);
        end
    end

    // Next-state logic; clear overrides everything, then per-state door/stop/start/keypad handling
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        presc_d = presc_q;
        phase_d = phase_q;
        pwr_d   = pwr_q;
        beep_d  = beep_q;
        done_d  = 1'b0;
        if (state_q == ST_RUN || state_q == ST_DONE) presc_d = tick ? '0 : presc_q + 1'b1;
        if (clear_p) begin
            state_d = ST_IDLE;
            dig_d   = '{default: '0};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_p && door_closed) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                        phase_d = '0;
                        pwr_d   = pwr_eff;
                        if (time_zero) begin
                            dig_d[1] = QS_TENS;
                            dig_d[0] = QS_ONES;
                        end
                    end else if (key_p) begin
                        for (int i = NDIG - 1; i > 0; i--) dig_d[i] = dig_q[i-1];
                        dig_d[0] = key_dig;
                    end
                end
                ST_RUN: begin
                    if (!door_closed || stop_p) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        dig_d   = dec;
                        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
                        if (dec_zero) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            beep_d  = '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (stop_p) begin
                        state_d = ST_IDLE;
                        dig_d   = '{default: '0};
                    end else if (start_p && door_closed) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                default: begin
                    if (key_p) begin
                        state_d  = ST_IDLE;
                        dig_d    = '{default: '0};
                        dig_d[0] = key_dig;
                    end else if (tick) begin
                        state_d = (beep_q == BEEP_LAST) ? ST_IDLE : ST_DONE;
                        beep_d  = beep_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // State registers plus previous-cycle copies of the buttons for edge detection
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            dig_q    <= '{default: '0};
            presc_q  <= '0;
            phase_q  <= '0;
            pwr_q    <= '0;
            beep_q   <= '0;
            done_q   <= 1'b0;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
            clearn_q <= 1'b1;
            keypad_q <= '0;
        end else begin
            state_q  <= state_d;
            dig_q    <= dig_d;
            presc_q  <= presc_d;
            phase_q  <= phase_d;
            pwr_q    <= pwr_d;
            beep_q   <= beep_d;
            done_q   <= done_d;
            startn_q <= startn;
            stopn_q  <= stopn;
            clearn_q <= clearn;
            keypad_q <= keypad;
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        assign time_bcd[4*g +: 4] = dig_q[g];
        bcd_to_7seg u_seg (
            .digit_i (dig_q[g]),
            .segs_o  (segs[7*g +: 7])
        );
    end

    assign state  = state_q;
    assign done   = done_q;
    assign beep   = state_q == ST_DONE;
    assign mag_on = (state_q == ST_RUN) & door_closed & (phase_q < pwr_q);

endmodule
